// File: rtl/fp32_pkg.sv
// Shared FP32 field layout, datapath constants and FSM/special-case encodings
// for the sequential single-precision subtractor.
package fp32_pkg;
  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;
  localparam int DP_W    = 27;  // hidden + 23 fraction + guard, round, sticky

  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    ALIGN,
    ADDSUB,
    NORM,
    ROUND,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    SP_NONE,
    SP_NAN,
    SP_INF,
    SP_ZERO
  } special_e;
endpackage

// File: rtl/fp32_classify.sv
// Combinational FP32 operand classifier; denormals are flushed to zero, so a
// zero exponent always yields a zero mantissa with no hidden bit.
module fp32_classify
  import fp32_pkg::*;
(
  input  logic [31:0]      x,
  output logic             sign,
  output logic [EXP_W-1:0] exp,
  output logic [MAN_W:0]   man,
  output logic             is_zero,
  output logic             is_inf,
  output logic             is_nan
);
  logic all_ones;

  assign sign     = x[31];
  assign exp      = x[30:23];
  assign all_ones = (x[30:23] == EXP_W'(EXP_MAX));
  assign is_zero  = (x[30:23] == '0);
  assign is_inf   = all_ones && (x[22:0] == '0);
  assign is_nan   = all_ones && (x[22:0] != '0);
  assign man      = is_zero ? '0 : {1'b1, x[22:0]};
endmodule

// File: rtl/fp_sub32_seq.sv
// Multi-cycle FP32 subtractor (out = A - B) with bit-serial alignment and
// normalization, round-to-nearest-even and flush-to-zero.
// Handshake: start is sampled only in IDLE; busy is high from the accept edge
// through the DONE cycle; done is a one-cycle pulse with out valid and held.
module fp_sub32_seq
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] out,
  output logic        busy,
  output logic        done,
  output state_e      dbg_state
);
  state_e state, state_n;

  logic [31:0] a_q, b_q, out_q;
  logic        sx, sy, rzero;
  logic [9:0]  ex;
  logic [27:0] mx;
  logic [26:0] my;
  logic [4:0]  cnt;

  logic             a_sign, b_sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W:0]   a_man, b_man;

  fp32_classify u_cls_a (.x(a_q), .sign(a_sign), .exp(a_exp), .man(a_man),
                         .is_zero(a_zero), .is_inf(a_inf), .is_nan(a_nan));
  fp32_classify u_cls_b (.x(b_q), .sign(b_sign), .exp(b_exp), .man(b_man),
                         .is_zero(b_zero), .is_inf(b_inf), .is_nan(b_nan));

  special_e    special;
  logic [31:0] spec_val;
  logic        a_ge, x_sign, y_sign;
  logic [EXP_W-1:0] x_exp, y_exp;
  logic [MAN_W:0]   x_man, y_man;
  logic [8:0]  ediff;
  logic [4:0]  d;
  logic        norm_done, rnd_up;
  logic [24:0] rsum;
  logic [9:0]  rexp;
  logic [31:0] round_val;

  // Subtrahend enters the datapath with its sign inverted.
  always_comb begin
    special  = SP_NONE;
    spec_val = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (a_sign == b_sign))) begin
      special  = SP_NAN;
      spec_val = QNAN;
    end else if (a_inf) begin
      special  = SP_INF;
      spec_val = {a_sign, 8'hFF, 23'b0};
    end else if (b_inf) begin
      special  = SP_INF;
      spec_val = {~b_sign, 8'hFF, 23'b0};
    end else if (a_zero && b_zero) begin
      special  = SP_ZERO;
      spec_val = {a_sign & ~b_sign, 31'b0};
    end
  end

  assign a_ge   = ({a_exp, a_man} >= {b_exp, b_man});
  assign x_sign = a_ge ? a_sign : ~b_sign;
  assign y_sign = a_ge ? ~b_sign : a_sign;
  assign x_exp  = a_ge ? a_exp : b_exp;
  assign y_exp  = a_ge ? b_exp : a_exp;
  assign x_man  = a_ge ? a_man : b_man;
  assign y_man  = a_ge ? b_man : a_man;
  assign ediff  = {1'b0, x_exp} - {1'b0, y_exp};
  assign d      = (ediff > 9'd27) ? 5'd27 : ediff[4:0];

  // A NORM cycle ends the phase when the value after this cycle's step is final.
  assign norm_done = mx[27] || mx[26] || mx[25] || (mx == '0) || (ex == 10'd1);

  assign rnd_up    = mx[2] & (mx[1] | mx[0] | mx[3]);
  assign rsum      = {1'b0, mx[26:3]} + {24'b0, rnd_up};
  assign rexp      = ex + {9'b0, rsum[24]};
  assign round_val = rzero ? {sx, 31'b0} :
                     (rexp >= 10'(EXP_MAX)) ? {sx, 8'hFF, 23'b0} :
                     {sx, rexp[7:0], rsum[22:0]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = UNPACK;
      UNPACK:  if (special != SP_NONE) state_n = DONE;
               else if (d == 5'd0)     state_n = ADDSUB;
               else                    state_n = ALIGN;
      ALIGN:   if (cnt == 5'd1) state_n = ADDSUB;
      ADDSUB:  state_n = NORM;
      NORM:    if (norm_done) state_n = ROUND;
      ROUND:   state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      out_q <= '0;
      sx    <= 1'b0;
      sy    <= 1'b0;
      rzero <= 1'b0;
      ex    <= '0;
      mx    <= '0;
      my    <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_q <= A;
          b_q <= B;
        end
        UNPACK: begin
          sx    <= x_sign;
          sy    <= y_sign;
          ex    <= {2'b0, x_exp};
          mx    <= {1'b0, x_man, 3'b0};
          my    <= {y_man, 3'b0};
          cnt   <= d;
          rzero <= 1'b0;
          if (special != SP_NONE) out_q <= spec_val;
        end
        ALIGN: begin
          my  <= {1'b0, my[26:2], my[1] | my[0]};
          cnt <= cnt - 5'd1;
        end
        ADDSUB: mx <= (sx ^ sy) ? (mx - {1'b0, my}) : (mx + {1'b0, my});
        NORM: begin
          if (mx[27]) begin
            mx <= {1'b0, mx[27:2], mx[1] | mx[0]};
            ex <= ex + 10'd1;
          end else if (mx[26]) begin
            mx <= mx;
          end else if (mx == '0) begin
            rzero <= 1'b1;
            sx    <= 1'b0;
          end else if (ex == 10'd1) begin
            rzero <= 1'b1;  // underflow: flush, keep the sign
          end else begin
            mx <= {mx[26:0], 1'b0};
            ex <= ex - 10'd1;
          end
        end
        ROUND:   out_q <= round_val;
        default: ;
      endcase
    end
  end

  assign out       = out_q;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign dbg_state = state;
endmodule

// File: tb/tb_fp_sub32_seq.sv
// Directed bench for fp_sub32_seq: hand-computed results and done latency,
// handshake behaviour, and mid-operation reset.
module tb_fp_sub32_seq;
  import fp32_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] A, B, out;
  logic        busy, done;
  state_e      dbg_state;

  int errors = 0;
  int checks = 0;

  fp_sub32_seq dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .out(out), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one operation; poke keeps start high with junk operands while busy.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_out, input int exp_cyc, input bit poke);
    int cyc;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    cyc = 1;
    if (!poke) start = 1'b0;
    A = $urandom; B = $urandom;
    check({tag, " busy"}, {31'b0, busy}, 32'd1);
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (poke) begin A = $urandom; B = $urandom; end
    end
    check({tag, " done"}, {31'b0, done}, 32'd1);
    check({tag, " cycle"}, 32'(cyc), 32'(exp_cyc));
    check({tag, " out"}, out, exp_out);
    start = 1'b0;
    @(negedge clk);
    check({tag, " idle"}, {30'b0, busy, done}, 32'd0);
    check({tag, " hold"}, out, exp_out);
  endtask

  initial begin
    int done_seen;
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    check("rst out", out, 32'h0);
    check("rst busy_done", {30'b0, busy, done}, 32'd0);
    check("rst state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;

    run_op("8.5-0.75",   32'h41080000, 32'h3F400000, 32'h40F80000, 9, 1'b0);
    run_op("1.5-1.75",   32'h3FC00000, 32'h3FE00000, 32'hBE800000, 6, 1'b0);
    run_op("3.5-1.5",    32'h40600000, 32'h3FC00000, 32'h40000000, 6, 1'b0);
    run_op("1-1.5",      32'h3F800000, 32'h3FC00000, 32'hBF000000, 5, 1'b0);
    run_op("1.5-1.5",    32'h3FC00000, 32'h3FC00000, 32'h00000000, 5, 1'b0);
    run_op("2^24-1",     32'h4B800000, 32'h3F800000, 32'h4B7FFFFF, 29, 1'b0);
    run_op("1.5+1.5",    32'h3FC00000, 32'hBFC00000, 32'h40400000, 5, 1'b0);
    run_op("rne tie",    32'h3F800000, 32'hB3800000, 32'h3F800000, 29, 1'b0);
    run_op("rne up",     32'h3F800000, 32'hB3C00000, 32'h3F800001, 29, 1'b0);
    run_op("ovf inf",    32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 5, 1'b0);
    run_op("inf-inf",    32'h7F800000, 32'h7F800000, 32'h7FC00000, 2, 1'b0);
    run_op("1-(-inf)",   32'h3F800000, 32'hFF800000, 32'h7F800000, 2, 1'b0);
    run_op("nan-1",      32'h7FC00001, 32'h3F800000, 32'h7FC00000, 2, 1'b0);
    run_op("-0-+0",      32'h80000000, 32'h00000000, 32'h80000000, 2, 1'b0);
    run_op("+0-+0",      32'h00000000, 32'h00000000, 32'h00000000, 2, 1'b0);
    run_op("busy poke",  32'h41080000, 32'h3F400000, 32'h40F80000, 9, 1'b1);

    // Reset during ALIGN of a long-alignment operation.
    @(negedge clk);
    A = 32'h4B800000; B = 32'h3F800000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid align state", 32'(dbg_state), 32'(ALIGN));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort out", out, 32'h0);
    check("abort busy_done", {30'b0, busy, done}, 32'd0);
    done_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("abort no done", 32'(done_seen), 32'd0);

    run_op("after rst",  32'h40600000, 32'h3FC00000, 32'h40000000, 6, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
